// File: rtl/avalon_burst_ram_slave.sv
// avalon_burst_ram_slave
//
// Avalon-MM responder backed by a single-port synchronous on-chip RAM with
// incrementing burst support. One instance terminates one crossbar output
// port for one memory-mapped RAM region.
//
// Ports:
//   i_Clk              sole clock, rising edge
//   i_Reset_n          synchronous active-low reset
//   i_AVS_Addr         word address, only the low ADDR_BITS bits are used
//   i_AVS_ByteEn       byte-lane write enables
//   i_AVS_Read         read request / read beat strobe
//   o_AVS_ReadData     read data, 0 outside accepted read beats
//   i_AVS_Write        write request / write beat strobe
//   i_AVS_WriteData    write data
//   o_AVS_WaitRequest  registered, 1 = beat not accepted
//   i_AVS_BurstCount   beats in burst, 0 treated as 1
//
// Build option:
//   AVALON_RAM_BYTEEN_EN  when defined, write lanes honour i_AVS_ByteEn;
//                         otherwise every write beat writes all 32 bits.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no burst, waitrequest high, accept a new read/write request
// S_RD_FETCH | RAM read of first word in flight, waitrequest high
// S_RD_BURST | read beats presented, one per cycle while Read is high
// S_WR_BURST | write beats accepted, one per cycle while Write is high

module avalon_burst_ram_slave #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [29:0] i_AVS_Addr,
    input  logic [3:0]  i_AVS_ByteEn,
    input  logic        i_AVS_Read,
    output logic [31:0] o_AVS_ReadData,
    input  logic        i_AVS_Write,
    input  logic [31:0] i_AVS_WriteData,
    output logic        o_AVS_WaitRequest,
    input  logic [7:0]  i_AVS_BurstCount
);

    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_FETCH,
        S_RD_BURST,
        S_WR_BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             count_q, count_d;
    logic                   wait_q, wait_d;

    logic [31:0]            mem [DEPTH_WORDS];
    logic [31:0]            ram_q;
    logic [ADDR_BITS-1:0]   ram_raddr;
    logic                   mem_we;

    logic [ADDR_BITS-1:0]   req_addr;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic [7:0]             req_count;

    // Upper address bits alias; byte enables are only consumed when the
    // lane-enable build option is on.
    logic unused_inputs;
`ifdef AVALON_RAM_BYTEEN_EN
    assign unused_inputs = ^i_AVS_Addr[29:ADDR_BITS];
`else
    assign unused_inputs = ^{i_AVS_Addr[29:ADDR_BITS], i_AVS_ByteEn};
`endif

    assign req_addr  = i_AVS_Addr[ADDR_BITS-1:0];
    assign req_count = (i_AVS_BurstCount == 8'd0) ? 8'd1 : i_AVS_BurstCount;
    // Natural wrap of the ADDR_BITS-wide sum gives modulo-DEPTH addressing.
    assign addr_inc  = addr_q + ADDR_BITS'(1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        ram_raddr = addr_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_AVS_Write) begin
                    addr_d  = req_addr;
                    count_d = req_count;
                    state_d = S_WR_BURST;
                end else if (i_AVS_Read) begin
                    addr_d    = req_addr;
                    count_d   = req_count;
                    ram_raddr = req_addr;
                    state_d   = S_RD_FETCH;
                end
            end
            S_RD_FETCH: begin
                state_d = S_RD_BURST;
            end
            S_RD_BURST: begin
                if (i_AVS_Read) begin
                    // Prefetch the next word so it is presented next cycle.
                    addr_d    = addr_inc;
                    count_d   = count_q - 8'd1;
                    ram_raddr = addr_inc;
                    if (count_q == 8'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_BURST: begin
                if (i_AVS_Write) begin
                    mem_we  = 1'b1;
                    addr_d  = addr_inc;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wait_d = !((state_d == S_RD_BURST) || (state_d == S_WR_BURST));
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= 8'd0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // RAM is not cleared by reset, but a beat strobed during reset must not
    // land: reset aborts the burst before that beat.
    always_ff @(posedge i_Clk) begin
        if (mem_we && i_Reset_n) begin
`ifdef AVALON_RAM_BYTEEN_EN
            for (int b = 0; b < 4; b++) begin
                if (i_AVS_ByteEn[b]) begin
                    mem[addr_q][8*b +: 8] <= i_AVS_WriteData[8*b +: 8];
                end
            end
`else
            mem[addr_q] <= i_AVS_WriteData;
`endif
        end
        ram_q <= mem[ram_raddr];
    end

    assign o_AVS_ReadData    = (state_q == S_RD_BURST) ? ram_q : 32'd0;
    assign o_AVS_WaitRequest = wait_q;

endmodule

// File: doc/avalon_burst_ram_slave.md
# avalon_burst_ram_slave

Avalon-MM responder that terminates one crossbar output port with a single-port synchronous on-chip RAM supporting incrementing bursts. It samples the slave-side signals driven by the crossbar (address, byte enable, read, write, write data, burst count) and returns read data and wait request. It is the target end of the interconnect's master-to-slave path, one instance per memory-mapped RAM region.

## Interface

- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- ADDR_BITS, $clog2(DEPTH_WORDS): word-index width; derived, not overridden.

- i_Clk  in  1  sole clock, all logic on rising edge.
- i_Reset_n  in  1  reset, synchronous, active-low.
- i_AVS_Addr  in  30  word address; only bits [ADDR_BITS-1:0] used, upper bits ignored (aliasing).
- i_AVS_ByteEn  in  4  byte-lane write enables, bit n = WriteData[8n+7:8n].
- i_AVS_Read  in  1  read request / read beat strobe.
- o_AVS_ReadData  out  32  read data, valid only when o_AVS_WaitRequest=0 in a read burst, else 0.
- i_AVS_Write  in  1  write request / write beat strobe.
- i_AVS_WriteData  in  32  write data.
- o_AVS_WaitRequest  out  1  registered; 1 = beat not accepted.
- i_AVS_BurstCount  in  8  beats in burst; 0 treated as 1.

## Operation

- States: IDLE, RD_FETCH, RD_BURST, WR_BURST.
- Internal: r_Addr (ADDR_BITS), r_Count (8), registered RAM output.
- IDLE: WaitRequest=1. Write=1 -> latch Addr, Count (0->1), go WR_BURST. Else Read=1 -> latch, issue RAM read at Addr, go RD_FETCH. Both high: write wins, read ignored.
- RD_FETCH: one cycle, WaitRequest=1; go RD_BURST.
- RD_BURST: WaitRequest=0, ReadData=RAM[r_Addr]. Beat accepted in a cycle with Read=1: r_Addr+1, r_Count-1, RAM prefetches new r_Addr so next beat is ready next cycle. Read=0: hold state, address, data. Last beat (r_Count=1) accepted -> IDLE.
- WR_BURST: WaitRequest=0. Cycle with Write=1: write WriteData to RAM[r_Addr] under lane enables, r_Addr+1, r_Count-1. Write=0: hold. Last beat -> IDLE.
- Write/Read and Addr/BurstCount ignored mid-burst except as beat strobes.
- Address arithmetic modulo DEPTH_WORDS: DEPTH_WORDS-1 increments to 0.
- Reset: state IDLE, WaitRequest=1, ReadData=0, r_Count=0, r_Addr=0; RAM contents not cleared. Reset mid-burst aborts it; beats already written persist.

## Timing

- WaitRequest is registered: 1 in cycle after last beat, 0 from second cycle of write burst, from third cycle of read burst.
- Read: request cycle T (wait), T+1 fetch (wait), first beat T+2, then 1 beat/cycle while Read held; N-beat read = N+2 cycles minimum.
- Write: request T (wait), first beat accepted T+1; N-beat write = N+1 cycles minimum.
- Back-to-back bursts: at least one IDLE cycle between bursts.
- Read-after-write to same word in a later burst returns new data (no bypass needed, write completes before IDLE).

## Configuration

- AVALON_RAM_BYTEEN_EN defined: each lane written only if its ByteEn bit is 1; ByteEn=0000 beat consumes a beat, changes nothing.
- Not defined: ByteEn ignored, every write beat writes all 32 bits.

## Test plan

- Reset then idle: WaitRequest=1, ReadData=0 for 5 cycles with Read=Write=0.
- Write Addr=0x10, BurstCount=4, data 0xA0..0xA3 with Write held; then read Addr=0x10, BurstCount=4 -> beats 0xA0,0xA1,0xA2,0xA3 on cycles T+2..T+5, WaitRequest back to 1 at T+6.
- Read burst of 3 with Read dropped for 2 cycles after beat 1 -> same data held, beats 2,3 follow on resumption, no skipped words.
- Write DEPTH_WORDS-2, BurstCount=4 -> words DEPTH_WORDS-2, DEPTH_WORDS-1, 0, 1 written; BurstCount=0 writes exactly one word.
- With AVALON_RAM_BYTEEN_EN: word 0x11223344, write 0xFFFFFFFF ByteEn=0101 -> reads 0x11FF33FF; without macro -> 0xFFFFFFFF.
- Assert i_Reset_n=0 after beat 2 of 8-beat write -> WaitRequest=1 next cycle, state IDLE; readback shows beats 1-2 written, words 3-8 unchanged; Read+Write together in IDLE performs write.
